// File: rtl/t01_button_ctrl.sv
// Button front end: per-button debounce, press and auto-repeat event generation,
// round-robin arbitration into a first-word-fall-through event FIFO.
module t01_button_ctrl #(
  parameter int NBTN          = 4,
  parameter int DB_CYCLES     = 16,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NBTN-1:0]         btn_sync,
  output logic [NBTN-1:0]         btn_level,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(NBTN)-1:0] evt_code,
  output logic                    evt_repeat,
  output logic                    overflow,
  input  logic                    clr_overflow
);
  localparam int CW   = $clog2(NBTN);
  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic {PH_HOLD, PH_REPEAT} phase_t;

  logic [NBTN-1:0] r_level, r_pend, r_rep;
  logic [DBW-1:0]  r_cnt   [NBTN];
  logic [HW-1:0]   r_hold  [NBTN];
  phase_t          r_phase [NBTN];
  logic [CW-1:0]   r_rr;
  logic            r_ovf;
  logic [CW-1:0]   r_mem_code [FIFO_DEPTH];
  logic            r_mem_rep  [FIFO_DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [AW:0]     r_count;

  logic [NBTN-1:0] w_level_n, w_pend_n, w_rep_n, w_evt, w_evt_rep;
  logic [DBW-1:0]  w_cnt_n   [NBTN];
  logic [HW-1:0]   w_hold_n  [NBTN];
  phase_t          w_phase_n [NBTN];
  logic            w_pop, w_can, w_gnt, w_push, w_drop;
  logic [CW-1:0]   w_gnt_idx, w_rr_n;
  int unsigned     w_idx;
  logic [AW-1:0]   w_head;

  // Debounce and event generation; one hold counter serves both the initial
  // hold delay and the repeat period, the phase selecting the terminal count.
  always_comb begin
    w_level_n = r_level;
    w_evt     = '0;
    w_evt_rep = '0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      w_cnt_n[i]   = '0;
      w_hold_n[i]  = r_hold[i];
      w_phase_n[i] = r_phase[i];
      if (btn_sync[i] != r_level[i]) begin
        if (r_cnt[i] == DBW'(DB_CYCLES - 1)) w_level_n[i] = ~r_level[i];
        else                                 w_cnt_n[i]   = r_cnt[i] + 1'b1;
      end
      if (w_level_n[i] && !r_level[i]) begin
        w_evt[i]     = 1'b1;
        w_hold_n[i]  = '0;
        w_phase_n[i] = PH_HOLD;
      end else if (r_level[i]) begin
        if (r_hold[i] + 1'b1 == ((r_phase[i] == PH_HOLD) ? HW'(HOLD_CYCLES)
                                                          : HW'(REPEAT_CYCLES))) begin
          w_evt[i]     = 1'b1;
          w_evt_rep[i] = 1'b1;
          w_hold_n[i]  = '0;
          w_phase_n[i] = PH_REPEAT;
        end else begin
          w_hold_n[i] = r_hold[i] + 1'b1;
        end
      end
    end
  end

  // Round-robin grant over pend bits registered at the previous edge.
  always_comb begin
    w_pop     = evt_valid & evt_ready;
    w_can     = (r_count != (AW+1)'(FIFO_DEPTH)) | w_pop;
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int unsigned k = 0; k < NBTN; k++) begin
      w_idx = r_rr + k;
      if (w_idx >= NBTN) w_idx = w_idx - NBTN;
      if (!w_gnt && r_pend[CW'(w_idx)]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = CW'(w_idx);
      end
    end
    w_push = w_gnt & w_can;
    w_rr_n = (w_gnt_idx == CW'(NBTN - 1)) ? '0 : w_gnt_idx + 1'b1;
    w_drop = |(w_evt & r_pend);
    w_pend_n = r_pend | w_evt;
    w_rep_n  = r_rep;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (w_evt[i] && !r_pend[i]) w_rep_n[i] = w_evt_rep[i];
    end
    if (w_push) w_pend_n[w_gnt_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_pend  <= '0;
      r_rep   <= '0;
      r_rr    <= '0;
      r_ovf   <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        r_cnt[i]   <= '0;
        r_hold[i]  <= '0;
        r_phase[i] <= PH_HOLD;
      end
      for (int unsigned d = 0; d < FIFO_DEPTH; d++) begin
        r_mem_code[d] <= '0;
        r_mem_rep[d]  <= 1'b0;
      end
    end else begin
      r_level <= w_level_n;
      r_pend  <= w_pend_n;
      r_rep   <= w_rep_n;
      for (int unsigned i = 0; i < NBTN; i++) begin
        r_cnt[i]   <= w_cnt_n[i];
        r_hold[i]  <= w_hold_n[i];
        r_phase[i] <= w_phase_n[i];
      end
      if (w_push) begin
        r_mem_code[r_wr] <= w_gnt_idx;
        r_mem_rep[r_wr]  <= r_rep[w_gnt_idx];
        r_wr             <= r_wr + 1'b1;
        r_rr             <= w_rr_n;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop)            r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  // When empty, point at the most recently popped slot so the outputs hold.
  assign w_head     = evt_valid ? r_rd : r_rd - 1'b1;
  assign btn_level  = r_level;
  assign evt_valid  = (r_count != '0);
  assign evt_code   = r_mem_code[w_head];
  assign evt_repeat = r_mem_rep[w_head];
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_t01_button_ctrl.sv
// Bench for t01_button_ctrl: directed scenarios checked cycle-by-cycle against
// an event-level model, plus literal expectations for each scenario.
module tb_t01_button_ctrl;
  localparam int NBTN  = 4;
  localparam int DB    = 4;
  localparam int HOLD  = 20;
  localparam int REP   = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst, evt_ready, clr_overflow;
  logic [NBTN-1:0] btn_sync, btn_level;
  logic            evt_valid, evt_repeat, overflow;
  logic [1:0]      evt_code;

  int errors = 0;
  int checks = 0;

  t01_button_ctrl #(
    .NBTN(NBTN), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .btn_sync(btn_sync), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_repeat(evt_repeat), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Model: run length of disagreeing samples, cycles since press, queue FIFO.
  bit m_lvl  [NBTN];
  int m_run  [NBTN];
  int m_age  [NBTN];
  bit m_pend [NBTN];
  bit m_rep  [NBTN];
  int m_rr;
  bit m_ovf;
  int m_code_q[$];
  bit m_rep_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NBTN; i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_age[i] = 0; m_pend[i] = 0; m_rep[i] = 0;
    end
    m_rr = 0;
    m_ovf = 0;
    m_code_q.delete();
    m_rep_q.delete();
  endtask

  task automatic model_step();
    bit pop, can, gv, drop, nl;
    bit ev [NBTN];
    bit er [NBTN];
    int gj, j;
    pop = (m_code_q.size() > 0) && evt_ready;
    can = (m_code_q.size() < DEPTH) || pop;
    gv = 0; gj = 0;
    for (int k = 0; k < NBTN; k++) begin
      j = (m_rr + k) % NBTN;
      if (!gv && m_pend[j]) begin gv = 1; gj = j; end
    end
    for (int i = 0; i < NBTN; i++) begin
      ev[i] = 0; er[i] = 0; nl = m_lvl[i];
      if (btn_sync[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin nl = !m_lvl[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
      if (!m_lvl[i] && nl) begin
        m_age[i] = 0; ev[i] = 1;
      end else if (m_lvl[i]) begin
        m_age[i]++;
        if (m_age[i] == HOLD || (m_age[i] > HOLD && (m_age[i] - HOLD) % REP == 0)) begin
          ev[i] = 1; er[i] = 1;
        end
      end
      m_lvl[i] = nl;
    end
    drop = 0;
    for (int i = 0; i < NBTN; i++) begin
      if (ev[i]) begin
        if (m_pend[i]) drop = 1;
        else begin m_pend[i] = 1; m_rep[i] = er[i]; end
      end
    end
    if (pop) begin void'(m_code_q.pop_front()); void'(m_rep_q.pop_front()); end
    if (gv && can) begin
      m_code_q.push_back(gj);
      m_rep_q.push_back(m_rep[gj]);
      m_pend[gj] = 0;
      m_rr = (gj + 1) % NBTN;
    end
    if (drop) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
  endtask

  always @(negedge clk) begin
    int lv;
    lv = 0;
    for (int i = 0; i < NBTN; i++) if (m_lvl[i]) lv = lv | (1 << i);
    chk("model_btn_level", int'(btn_level), lv);
    chk("model_evt_valid", int'(evt_valid), int'(m_code_q.size() > 0));
    chk("model_overflow", int'(overflow), int'(m_ovf));
    if (m_code_q.size() > 0) begin
      chk("model_evt_code", int'(evt_code), m_code_q[0]);
      chk("model_evt_repeat", int'(evt_repeat), int'(m_rep_q[0]));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step(1);
    rst = 1'b0;
  endtask

  int offs[$];
  int reps[$];
  int exp_off [4] = '{1, 21, 29, 37};
  int exp_rep [4] = '{0, 1, 1, 1};

  initial begin
    rst = 1'b0; btn_sync = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_code", int'(evt_code), 0);
    chk("reset_repeat", int'(evt_repeat), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_level", int'(btn_level), 0);

    // 1. three-cycle glitch is rejected
    btn_sync = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("glitch_level", int'(btn_level), 0);
    end
    btn_sync = '0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("glitch_valid", int'(evt_valid), 0);
    end

    // 2. clean press on button 2
    do_reset();
    evt_ready = 1'b1;
    btn_sync = 4'b0100;
    step(3);
    chk("press_level_early", int'(btn_level), 0);
    step(1);
    chk("press_level_E", int'(btn_level), 4);
    chk("press_valid_E", int'(evt_valid), 0);
    step(1);
    chk("press_valid_E1", int'(evt_valid), 1);
    chk("press_code_E1", int'(evt_code), 2);
    chk("press_rep_E1", int'(evt_repeat), 0);
    step(1);
    chk("press_popped", int'(evt_valid), 0);
    btn_sync = '0;
    step(6);

    // 3. simultaneous presses
    do_reset();
    btn_sync = 4'b1010;
    step(4);
    chk("simul_level", int'(btn_level), 10);
    step(1);
    chk("simul_first_code", int'(evt_code), 1);
    step(1);
    chk("simul_second_valid", int'(evt_valid), 1);
    chk("simul_second_code", int'(evt_code), 3);
    step(1);
    chk("simul_empty", int'(evt_valid), 0);
    btn_sync = '0;
    step(6);
    btn_sync = 4'b0011;
    step(5);
    chk("simul2_first_code", int'(evt_code), 0);
    step(1);
    chk("simul2_second_code", int'(evt_code), 1);
    step(1);
    chk("simul2_empty", int'(evt_valid), 0);
    btn_sync = '0;
    step(6);

    // 4. auto-repeat on button 0
    do_reset();
    btn_sync = 4'b0001;
    step(4);
    chk("rep_level_E", int'(btn_level), 1);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (evt_valid) begin offs.push_back(k); reps.push_back(int'(evt_repeat)); end
      if (k == 38) btn_sync = '0;
    end
    chk("rep_event_count", offs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rep_offset", (i < offs.size()) ? offs[i] : -1, exp_off[i]);
      chk("rep_flag", (i < reps.size()) ? reps[i] : -1, exp_rep[i]);
    end
    step(6);

    // 5. backpressure and overflow
    do_reset();
    evt_ready = 1'b0;
    btn_sync = 4'b1111;
    step(8);
    chk("bp_full_valid", int'(evt_valid), 1);
    chk("bp_full_code", int'(evt_code), 0);
    chk("bp_ovf_fill", int'(overflow), 0);
    step(16);
    chk("bp_ovf_pend", int'(overflow), 0);
    step(8);
    chk("bp_ovf_set", int'(overflow), 1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("bp_ovf_clr", int'(overflow), 0);
    btn_sync = '0;
    step(5);
    chk("bp_head0", int'(evt_code), 0);
    evt_ready = 1'b1;
    step(1);
    chk("bp_drain1", int'(evt_code), 1);
    step(1);
    chk("bp_drain2", int'(evt_code), 2);
    step(1);
    chk("bp_drain3", int'(evt_code), 3);
    step(1);
    chk("bp_drain_rep_code", int'(evt_code), 0);
    chk("bp_drain_rep_flag", int'(evt_repeat), 1);
    step(4);
    chk("bp_drained", int'(evt_valid), 0);

    // 6. asynchronous reset mid-operation
    do_reset();
    evt_ready = 1'b0;
    btn_sync = 4'b1111;
    step(6);
    chk("arst_before_valid", int'(evt_valid), 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_valid", int'(evt_valid), 0);
    chk("arst_level", int'(btn_level), 0);
    btn_sync = '0;
    step(2);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      chk("arst_no_event", int'(evt_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
